// File: rtl/tribus_arbiter.sv
// Round-robin owner selection and enable sequencing for a shared tristate bus.
// At most one driver enable is high; owner changes are separated by all-off turnaround cycles.
module tribus_arbiter #(
  parameter int N         = 4,
  parameter int OWNER_W   = 2,
  parameter int TA_CYCLES = 1,
  parameter int MAX_HOLD  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       req,
  output logic [N-1:0]       gnt,
  output logic [N-1:0]       oe,
  output logic [OWNER_W-1:0] owner,
  output logic               busy
);

  // state      | meaning
  // IDLE       | no owner, all enables low, waiting for any request
  // GRANT      | one driver enabled, hold counter tracks tenure
  // TURNAROUND | all enables low for TA_CYCLES cycles, arbitrates in the last one
  typedef enum logic [1:0] {IDLE, GRANT, TURNAROUND} state_t;

  state_t             state_q, state_d;
  logic [N-1:0]       gnt_q, gnt_d;
  logic [OWNER_W-1:0] owner_q, owner_d;
  logic [OWNER_W-1:0] ptr_q, ptr_d;
  logic [7:0]         hold_q, hold_d;
  logic [3:0]         ta_q, ta_d;

  logic [2*N-1:0]     req_dbl;
  logic [N-1:0]       req_rot;
  logic [OWNER_W-1:0] win;
  logic               win_vld;
  logic               own_req, others_req, hold_tc, ta_last;
  logic [OWNER_W-1:0] ptr_after_owner;

  // Rotate so bit 0 is the requester at ptr; the first set bit is the winner.
  assign req_dbl = {req, req};
  assign req_rot = N'(req_dbl >> ptr_q);

  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!win_vld && req_rot[i]) begin
        win_vld = 1'b1;
        win     = OWNER_W'((int'(ptr_q) + i) % N);
      end
    end
  end

  // gnt_q is one-hot at the owner while in GRANT.
  assign own_req         = |(req & gnt_q);
  assign others_req      = |(req & ~gnt_q);
  assign hold_tc         = (hold_q == 8'(MAX_HOLD));
  assign ta_last         = (ta_q == 4'd1);
  assign ptr_after_owner = (owner_q == OWNER_W'(N - 1)) ? '0 : owner_q + 1'b1;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    ta_d    = ta_q;
    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d = GRANT;
          gnt_d   = N'(1) << win;
          owner_d = win;
          hold_d  = 8'd1;
        end
      end
      GRANT: begin
        if (!own_req || (hold_tc && others_req)) begin
          state_d = TURNAROUND;
          gnt_d   = '0;
          ptr_d   = ptr_after_owner;
          ta_d    = 4'(TA_CYCLES);
        end else if (hold_tc) begin
          hold_d = 8'd1;
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      TURNAROUND: begin
        if (ta_last) begin
          ta_d = 4'd0;
          if (win_vld) begin
            state_d = GRANT;
            gnt_d   = N'(1) << win;
            owner_d = win;
            hold_d  = 8'd1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          ta_d = ta_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
      ta_q    <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      ta_q    <= ta_d;
    end
  end

  assign gnt   = gnt_q;
  assign oe    = gnt_q;
  assign owner = owner_q;
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_tribus_arbiter.sv
// Self-checking bench for tribus_arbiter: directed scenarios plus random traffic
// compared cycle by cycle against a behavioural bus-ownership model.
module tb_tribus_arbiter;
  localparam int N  = 4;
  localparam int OW = 2;
  localparam int TA = 1;
  localparam int MH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req = '0;
  logic [N-1:0]  gnt, oe;
  logic [OW-1:0] owner;
  logic          busy;

  int n_cmp = 0;
  int n_bad = 0;

  // model: current grantee (-1 none), last owner, tenure, turnaround cycles left, rr pointer
  int m_gnt, m_own, m_hold, m_gap, m_ptr;

  tribus_arbiter #(.N(N), .OWNER_W(OW), .TA_CYCLES(TA), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt), .oe(oe), .owner(owner), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int i = 0; i < N; i++) begin
      if (r[(p + i) % N]) return (p + i) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] m_vec();
    logic [N-1:0] one;
    one = 1;
    return (m_gnt < 0) ? '0 : (one << m_gnt);
  endfunction

  function automatic logic m_busy();
    return (m_gnt >= 0) || (m_gap > 0);
  endfunction

  task automatic model_reset();
    m_gnt = -1; m_own = 0; m_hold = 0; m_gap = 0; m_ptr = 0;
  endtask

  task automatic model_step(input logic [N-1:0] r);
    int w;
    if (m_gnt >= 0) begin
      if (!r[m_gnt] || (m_hold == MH && (r & ~m_vec()) != 0)) begin
        m_ptr = (m_own + 1) % N;
        m_gnt = -1;
        m_gap = TA;
      end else begin
        m_hold = (m_hold == MH) ? 1 : m_hold + 1;
      end
    end else begin
      w = -1;
      if (m_gap == 0 || m_gap == 1) w = pick(r, m_ptr);
      if (m_gap > 1) m_gap--;
      else begin
        m_gap = 0;
        if (w >= 0) begin m_gnt = w; m_own = w; m_hold = 1; end
      end
    end
  endtask

  task automatic tick();
    model_step(req);
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req   = '0;
    @(posedge clk);
    #1;
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 4'b1111;
    #2;
    n_cmp++; if (oe !== 4'b0000) begin n_bad++; $display("FAIL reset_oe_async got=%b want=0000", oe); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_cmp++; if (gnt !== 4'b0000) begin n_bad++; $display("FAIL reset_gnt got=%b want=0000", gnt); end
    n_cmp++; if (oe !== 4'b0000) begin n_bad++; $display("FAIL reset_oe got=%b want=0000", oe); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_cmp++; if (owner !== 2'd0) begin n_bad++; $display("FAIL reset_owner got=%0d want=0", owner); end
    model_reset();
    rst_n = 1'b1;
    req   = 4'b0100;
    tick();
    n_cmp++; if (gnt !== 4'b0100) begin n_bad++; $display("FAIL first_grant got=%b want=0100", gnt); end
    n_cmp++; if (owner !== 2'd2) begin n_bad++; $display("FAIL first_owner got=%0d want=2", owner); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL first_busy got=%b want=1", busy); end
  endtask

  // continues from test_reset: requester 2 owns the bus in cycle 1
  task automatic test_release_turnaround();
    for (int c = 2; c <= 5; c++) begin
      tick();
      n_cmp++; if (gnt !== 4'b0100) begin n_bad++; $display("FAIL hold_c%0d got=%b want=0100", c, gnt); end
    end
    req = 4'b0011;
    tick();
    n_cmp++; if (oe !== 4'b0000) begin n_bad++; $display("FAIL release_oe got=%b want=0000", oe); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL ta_busy got=%b want=1", busy); end
    n_cmp++; if (owner !== 2'd2) begin n_bad++; $display("FAIL ta_owner got=%0d want=2", owner); end
    tick();
    n_cmp++; if (gnt !== 4'b0001) begin n_bad++; $display("FAIL after_ta_gnt got=%b want=0001", gnt); end
    n_cmp++; if (owner !== 2'd0) begin n_bad++; $display("FAIL after_ta_owner got=%0d want=0", owner); end
  endtask

  task automatic test_preemption();
    logic [N-1:0] exp_seq [11];
    exp_seq = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000,
                4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0001};
    apply_reset();
    req = 4'b0011;
    for (int c = 0; c < 11; c++) begin
      tick();
      n_cmp++;
      if (gnt !== exp_seq[c] || !$onehot0(oe)) begin
        n_bad++; $display("FAIL preempt_c%0d got=%b want=%b", c + 1, gnt, exp_seq[c]);
      end
    end
  endtask

  task automatic test_sole();
    apply_reset();
    req = 4'b1000;
    tick();
    for (int c = 0; c < 20; c++) begin
      tick();
      n_cmp++;
      if (gnt !== 4'b1000 || busy !== 1'b1) begin
        n_bad++; $display("FAIL sole_c%0d got=%b/%b want=1000/1", c, gnt, busy);
      end
    end
    req = 4'b0000;
    tick();
    req = 4'b1000;
    tick();
    tick();
    n_cmp++; if (gnt !== 4'b1000) begin n_bad++; $display("FAIL sole_regrant got=%b want=1000", gnt); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    req = 4'b0010;
    tick();
    req = 4'b0000;
    tick();
    tick();
    req = 4'b0010;
    tick();
    n_cmp++; if (gnt !== 4'b0010) begin n_bad++; $display("FAIL ar_pre_gnt got=%b want=0010", gnt); end
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (oe !== 4'b0000) begin n_bad++; $display("FAIL ar_oe_now got=%b want=0000", oe); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ar_busy_now got=%b want=0", busy); end
    req = 4'b1001;
    @(posedge clk); #1;
    model_reset();
    rst_n = 1'b1;
    tick();
    n_cmp++; if (gnt !== 4'b0001) begin n_bad++; $display("FAIL ar_next_gnt got=%b want=0001", gnt); end
  endtask

  task automatic test_fairness();
    int cnt [N];
    foreach (cnt[k]) cnt[k] = 0;
    apply_reset();
    req = 4'b1111;
    for (int c = 0; c < 40; c++) begin
      tick();
      n_cmp++;
      if (gnt !== m_vec() || oe !== gnt || !$onehot0(oe)) begin
        n_bad++; $display("FAIL fair_c%0d got=%b want=%b", c + 1, gnt, m_vec());
      end
      for (int k = 0; k < N; k++) if (gnt[k]) cnt[k]++;
    end
    for (int k = 0; k < N; k++) begin
      n_cmp++;
      if (cnt[k] < 4 || cnt[k] > 12) begin
        n_bad++; $display("FAIL fair_share_%0d got=%0d want=8+-4", k, cnt[k]);
      end
    end
  endtask

  task automatic test_random();
    logic [N-1:0] prev_oe;
    int off_run;
    bit had;
    apply_reset();
    prev_oe = '0; off_run = 0; had = 0;
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < N; k++) if ($urandom_range(5) == 0) req[k] = ~req[k];
      tick();
      n_cmp++;
      if (gnt !== m_vec() || owner !== OW'(m_own) || busy !== m_busy()) begin
        n_bad++;
        $display("FAIL rand_c%0d got=%b/%0d/%b want=%b/%0d/%b", c, gnt, owner, busy, m_vec(), m_own, m_busy());
      end
      n_cmp++;
      if (oe !== gnt || !$onehot0(oe)) begin
        n_bad++; $display("FAIL rand_inv_c%0d oe=%b gnt=%b", c, oe, gnt);
      end
      if (oe != 0 && oe != prev_oe && had) begin
        n_cmp++;
        if (prev_oe != 0 || off_run < TA) begin
          n_bad++; $display("FAIL rand_gap_c%0d got=%0d want>=%0d", c, off_run, TA);
        end
      end
      if (oe != 0) begin had = 1; off_run = 0; end
      else off_run++;
      prev_oe = oe;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_release_turnaround();
    test_preemption();
    test_sole();
    test_async_reset();
    test_fairness();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
